jstk_poll_sched: RTL and testbench
==================================

# jstk_poll_sched

Periodic poll scheduler for the SPI joystick transfer controller. It issues one 5-byte transfer every `POLL_CYCLES` clocks, drives the send-receive handshake and the LED command byte, and supervises each transfer with a timeout. It captures the 40-bit result and decodes it into X/Y position, button state and a snake direction with a dead zone and 180° reversal rejection. It sits between the SPI transfer controller and the game logic, and runs on the same ~66.67 kHz clock.

## Interface
- `POLL_CYCLES`, 1000: clocks from the end of one transfer to the next request (~15 ms).
- `TIMEOUT_CYCLES`, 255: maximum clocks spent in REQ plus XFER before the transfer is abandoned.
- `CENTER`, 512: joystick rest value, both axes.
- `DEADZONE`, 200: |offset| ≤ DEADZONE on both axes gives no direction.

- `CLK` in 1: clock; all state updates on the rising edge. The transfer controller uses the falling edge of the same clock.
- `RESET_N` in 1: asynchronous, active-low reset.
- `EN` in 1: polling enable; sampled only in IDLE.
- `LED` in 2: LED request, copied into the command byte.
- `SS` in 1: slave select observed from the transfer controller, active low.
- `DOUT` in 40: transfer result from the controller; valid once `SS` has returned high.
- `sndRec` out 1: transfer request to the controller.
- `DIN` out 8: command byte `{6'b100000, LED[1], LED[0]}`.
- `X`, `Y` out 10 each: last captured position.
- `BTN` out 3: last captured buttons (bit0 stick, bit1 BTN1, bit2 BTN2).
- `DIR` out 2: direction code; UP=0, RIGHT=1, DOWN=2, LEFT=3.
- `dir_valid` out 1: one-cycle pulse when `DIR` changes.
- `sample_valid` out 1: one-cycle pulse when X/Y/BTN are updated.
- `timeout_err` out 1: sticky flag; set on timeout, cleared by the next successful capture.

## Operation
FSM states are IDLE, REQ, XFER, CAPTURE and RELEASE.

- **IDLE**
  - `sndRec`=0; the period counter increments.
  - When counter = POLL_CYCLES-1 and `EN`=1: clear the counter and go to REQ.
  - When counter = POLL_CYCLES-1 and `EN`=0: the counter saturates and the FSM stays in IDLE.
- **REQ**
  - `sndRec`=1; `DIN` is refreshed from `LED` every cycle.
  - `SS`=0 → XFER.
- **XFER**
  - `sndRec`=1; `DIN` is frozen.
  - `SS`=1 → CAPTURE.
- **CAPTURE** (one cycle)
  - X = {DOUT[25:24], DOUT[39:32]}.
  - Y = {DOUT[9:8], DOUT[23:16]}.
  - BTN = DOUT[2:0].
  - Pulse `sample_valid`, clear `timeout_err`, run the direction update, go to RELEASE.
- **RELEASE**
  - `sndRec`=0 for exactly one cycle, which lets the controller return to Idle, then → IDLE.
- **Timeout**: a watchdog counter clears on entry to REQ and increments in REQ and XFER. On reaching TIMEOUT_CYCLES: set `timeout_err`, go to RELEASE, and leave X/Y/BTN/DIR unchanged.
- **Direction update**
  - dx = X−CENTER and dy = Y−CENTER, as 11-bit signed values.
  - If |dx| ≤ DEADZONE and |dy| ≤ DEADZONE: no candidate.
  - Else, if |dx| ≥ |dy| (a tie goes to X): candidate is RIGHT when dx>0, else LEFT.
  - Else: candidate is UP when dy>0, else DOWN.
  - Accept the candidate only if it differs from `DIR` and is not `DIR`^2 (its opposite). On accept, update `DIR` and pulse `dir_valid`.
- **Reset values**: `sndRec`=0, `DIN`=8'h80, X=Y=0, `BTN`=0, `DIR`=RIGHT, all pulses 0, `timeout_err`=0, both counters 0, state IDLE.
- **Reset mid-transfer**: `sndRec` drops immediately. The controller recovers through its own Done→Idle path because `sndRec` is then 0.

## Timing
- All outputs are registered. `sndRec` rises in the first REQ cycle.
- `sample_valid` and `dir_valid` assert in the cycle after `SS` is seen high (CAPTURE); X/Y/BTN/DIR change on the same edge.
- Request-to-request spacing = POLL_CYCLES + transfer duration + 2 (CAPTURE + RELEASE).
- `SS` is generated on the falling edge, so it is stable at the rising edge and needs no synchronizer.
- If `SS` is already low on REQ entry (stale), REQ→XFER in one cycle. This is legal.
- `EN` deasserted during REQ or XFER does not abort the transfer; it stops only the next request.

## Structure
- Shared package (`jstk_pkg`) holds:
  - direction codes UP/RIGHT/DOWN/LEFT;
  - the command-byte prefix 6'b100000;
  - DOUT field offsets;
  - the FSM state encoding.
- One sub-module, `jstk_dir_decode`: a purely combinational mapping (X, Y, current DIR) → (candidate, accept), with CENTER/DEADZONE parameters. Registering stays in the parent.

## Test plan
- Reset, then EN=1 with POLL_CYCLES=4 → `sndRec` rises 4 cycles after reset release. A controller model returns DOUT=40'hFF_03_00_02_05 → X=1023, Y=512, BTN=3'b101, DIR stays RIGHT with no `dir_valid` (same direction).
- DIR=RIGHT; sample X=0, Y=512 → LEFT is rejected as a reversal: no `dir_valid`, DIR=1. Next sample X=512, Y=1023 → DIR=UP(0) with a one-cycle `dir_valid`.
- X=712, Y=312 (tie, |dx|=|dy|=200 ≤ DEADZONE) → no candidate. X=713, Y=311 → tie beyond the dead zone, X wins → RIGHT (no change if already RIGHT).
- Model never drops `SS`, TIMEOUT_CYCLES=8 → `timeout_err`=1 after 8 cycles, one RELEASE cycle with `sndRec`=0, outputs unchanged. The next good transfer clears `timeout_err` together with `sample_valid`.
- RESET_N pulled low while in XFER → `sndRec`=0 asynchronously and all outputs return to reset values. After release, a normal poll completes.
- LED=2'b10 while in REQ → DIN=8'h82. LED changed during XFER → DIN held at 8'h82 until the next REQ.

Source files
------------

// File: rtl/jstk_pkg.sv
// Shared definitions for the joystick poll scheduler: direction codes, FSM encoding,
// command-byte prefix and result-word field offsets.
package jstk_pkg;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirRight = 2'd1,
        DirDown  = 2'd2,
        DirLeft  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StXfer,
        StCapture,
        StRelease
    } state_e;

    localparam logic [5:0] CmdPrefix = 6'b100000;

    // Bit offsets of the position/button fields inside the 40-bit transfer result
    localparam int unsigned XLoLsb = 32;
    localparam int unsigned XHiLsb = 24;
    localparam int unsigned YLoLsb = 16;
    localparam int unsigned YHiLsb = 8;
    localparam int unsigned BtnLsb = 0;

endpackage

// File: rtl/jstk_dir_decode.sv
// Combinational direction decoder: maps a joystick position and the current direction to a
// candidate direction and whether it may be accepted (dead zone, no 180-degree reversal).
module jstk_dir_decode
    import jstk_pkg::*;
#(
    parameter int unsigned CENTER   = 512,
    parameter int unsigned DEADZONE = 200
) (
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic [1:0] dir_i,
    output logic [1:0] cand_o,
    output logic       accept_o
);

    logic signed [10:0] dx, dy;
    logic [10:0]        abs_x, abs_y;
    logic               in_dead;
    dir_e               cand;

    always_comb begin
        dx      = {1'b0, x_i} - 11'(CENTER);
        dy      = {1'b0, y_i} - 11'(CENTER);
        abs_x   = dx[10] ? 11'(-dx) : 11'(dx);
        abs_y   = dy[10] ? 11'(-dy) : 11'(dy);
        in_dead = (abs_x <= 11'(DEADZONE)) && (abs_y <= 11'(DEADZONE));

        // Ties between the axes resolve towards X
        if (abs_x >= abs_y) begin
            cand = (!dx[10] && (dx != '0)) ? DirRight : DirLeft;
        end else begin
            cand = (!dy[10] && (dy != '0)) ? DirUp : DirDown;
        end

        cand_o   = cand;
        accept_o = !in_dead && (cand != dir_i) && (cand != (dir_i ^ 2'b10));
    end

endmodule

// File: rtl/jstk_poll_sched.sv
// Periodic poll scheduler for the SPI joystick controller: issues a transfer every POLL_CYCLES
// clocks, supervises it with a watchdog, captures the result and tracks the snake direction.
module jstk_poll_sched
    import jstk_pkg::*;
#(
    parameter int unsigned POLL_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CENTER         = 512,
    parameter int unsigned DEADZONE       = 200
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        EN,
    input  logic [1:0]  LED,
    input  logic        SS,
    input  logic [39:0] DOUT,
    output logic        sndRec,
    output logic [7:0]  DIN,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic [2:0]  BTN,
    output logic [1:0]  DIR,
    output logic        dir_valid,
    output logic        sample_valid,
    output logic        timeout_err
);

    localparam int unsigned PollW = $clog2(POLL_CYCLES + 1);
    localparam int unsigned TimeW = $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    logic [PollW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [TimeW-1:0]   wdog_q, wdog_d;
    logic               wdog_expired;

    logic               snd_rec_q, snd_rec_d;
    logic [7:0]         din_q, din_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic [2:0]         btn_q, btn_d;
    logic [1:0]         dir_q, dir_d;
    logic               dir_valid_q, dir_valid_d;
    logic               sample_valid_q, sample_valid_d;
    logic               timeout_err_q, timeout_err_d;

    logic [9:0]         cap_x, cap_y;
    logic [1:0]         cand;
    logic               accept;
    logic               unused_dout;

    assign cap_x       = {DOUT[XHiLsb +: 2], DOUT[XLoLsb +: 8]};
    assign cap_y       = {DOUT[YHiLsb +: 2], DOUT[YLoLsb +: 8]};
    assign unused_dout = ^{DOUT[31:26], DOUT[15:10], DOUT[7:3]};

    jstk_dir_decode #(
        .CENTER   (CENTER),
        .DEADZONE (DEADZONE)
    ) u_dir_decode (
        .x_i      (cap_x),
        .y_i      (cap_y),
        .dir_i    (dir_q),
        .cand_o   (cand),
        .accept_o (accept)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            poll_cnt_q <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        poll_cnt_d   = poll_cnt_q;
        wdog_d       = wdog_q;
        wdog_expired = (wdog_q == TimeW'(TIMEOUT_CYCLES - 1));
        unique case (state_q)
            StIdle: begin
                // Counter saturates at its last value while polling is disabled
                if (poll_cnt_q == PollW'(POLL_CYCLES - 1)) begin
                    if (EN) begin
                        poll_cnt_d = '0;
                        wdog_d     = '0;
                        state_d    = StReq;
                    end
                end else begin
                    poll_cnt_d = poll_cnt_q + PollW'(1);
                end
            end
            StReq: begin
                if (wdog_expired) begin
                    state_d = StRelease;
                end else begin
                    wdog_d = wdog_q + TimeW'(1);
                    if (!SS) state_d = StXfer;
                end
            end
            StXfer: begin
                if (SS) begin
                    state_d = StCapture;
                end else if (wdog_expired) begin
                    state_d = StRelease;
                end else begin
                    wdog_d = wdog_q + TimeW'(1);
                end
            end
            StCapture: state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output next-state is derived from the transition so every output is registered
    always_comb begin
        snd_rec_d      = (state_d == StReq) || (state_d == StXfer);
        din_d          = (state_d == StReq) ? {CmdPrefix, LED} : din_q;
        x_d            = x_q;
        y_d            = y_q;
        btn_d          = btn_q;
        dir_d          = dir_q;
        dir_valid_d    = 1'b0;
        sample_valid_d = 1'b0;
        timeout_err_d  = timeout_err_q;
        if (state_q == StXfer && state_d == StCapture) begin
            x_d            = cap_x;
            y_d            = cap_y;
            btn_d          = DOUT[BtnLsb +: 3];
            sample_valid_d = 1'b1;
            timeout_err_d  = 1'b0;
            if (accept) begin
                dir_d       = cand;
                dir_valid_d = 1'b1;
            end
        end
        if ((state_q == StReq || state_q == StXfer) && state_d == StRelease) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            snd_rec_q      <= 1'b0;
            din_q          <= {CmdPrefix, 2'b00};
            x_q            <= '0;
            y_q            <= '0;
            btn_q          <= '0;
            dir_q          <= DirRight;
            dir_valid_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            snd_rec_q      <= snd_rec_d;
            din_q          <= din_d;
            x_q            <= x_d;
            y_q            <= y_d;
            btn_q          <= btn_d;
            dir_q          <= dir_d;
            dir_valid_q    <= dir_valid_d;
            sample_valid_q <= sample_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign sndRec       = snd_rec_q;
    assign DIN          = din_q;
    assign X            = x_q;
    assign Y            = y_q;
    assign BTN          = btn_q;
    assign DIR          = dir_q;
    assign dir_valid    = dir_valid_q;
    assign sample_valid = sample_valid_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_jstk_poll_sched.sv
// Scoreboard bench for jstk_poll_sched: a controller model drives SS/DOUT on the falling edge,
// expected captures are queued and a monitor compares them whenever sample_valid pulses.
module tb_jstk_poll_sched;

    localparam int PollCycles    = 4;
    localparam int TimeoutCycles = 8;
    localparam int Center        = 512;
    localparam int Deadzone      = 200;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        EN;
    logic [1:0]  LED;
    logic        SS;
    logic [39:0] DOUT;
    logic        sndRec;
    logic [7:0]  DIN;
    logic [9:0]  X, Y;
    logic [2:0]  BTN;
    logic [1:0]  DIR;
    logic        dir_valid, sample_valid, timeout_err;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
        logic [1:0] dir;
        logic       dv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_x, m_y, m_btn, m_dir;
    bit   m_err;

    jstk_poll_sched #(
        .POLL_CYCLES    (PollCycles),
        .TIMEOUT_CYCLES (TimeoutCycles),
        .CENTER         (Center),
        .DEADZONE       (Deadzone)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .EN           (EN),
        .LED          (LED),
        .SS           (SS),
        .DOUT         (DOUT),
        .sndRec       (sndRec),
        .DIN          (DIN),
        .X            (X),
        .Y            (Y),
        .BTN          (BTN),
        .DIR          (DIR),
        .dir_valid    (dir_valid),
        .sample_valid (sample_valid),
        .timeout_err  (timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference direction rule on plain integers; updates m_dir, returns 1 on a change
    function automatic bit model_dir_step(input int x, input int y);
        int dx, dy, ax, ay, cand;
        dx = x - Center;
        dy = y - Center;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        if (ax <= Deadzone && ay <= Deadzone) return 1'b0;
        if (ax >= ay) cand = (dx > 0) ? 1 : 3;
        else          cand = (dy > 0) ? 0 : 2;
        if (cand == m_dir || cand == (m_dir + 2) % 4) return 1'b0;
        m_dir = cand;
        return 1'b1;
    endfunction

    function automatic logic [39:0] mk_dout(input int x, input int y, input int btn);
        logic [39:0] d;
        d[31:0]  = $urandom;
        d[39:32] = 8'(x);
        d[25:24] = 2'(x >> 8);
        d[23:16] = 8'(y);
        d[9:8]   = 2'(y >> 8);
        d[2:0]   = 3'(btn);
        return d;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_btn = 0; m_dir = 1; m_err = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (sndRec !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic xfer(input logic [39:0] d, input int ex, input int ey, input int eb,
                        input int lat, input int len, input bit chg);
        int   n;
        logic [1:0] led0;
        exp_t e;
        wait_req(n);
        check("req_seen", sndRec, 1);
        if (sndRec !== 1'b1) return;
        check("din_in_req", DIN, {6'b100000, LED});
        check("err_before_xfer", timeout_err, m_err);
        led0 = LED;
        repeat (lat) @(negedge CLK);
        SS = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            if (chg && i == 0) LED = ~LED;
            if (chg && i == 1) check("din_frozen", DIN, {6'b100000, led0});
        end
        e.x   = 10'(ex);
        e.y   = 10'(ey);
        e.btn = 3'(eb);
        e.dv  = model_dir_step(ex, ey);
        e.dir = 2'(m_dir);
        m_x = ex; m_y = ey; m_btn = eb; m_err = 1'b0;
        exp_q.push_back(e);
        DOUT = d;
        SS   = 1'b1;
        n = 0;
        while (sndRec !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("req_dropped", sndRec, 0);
    endtask

    task automatic xfer_timeout();
        int n;
        wait_req(n);
        check("req_seen_to", sndRec, 1);
        n = 0;
        while (sndRec === 1'b1 && n < 50) begin
            n++;
            @(negedge CLK);
        end
        check("timeout_len", n, TimeoutCycles);
        check("timeout_err_set", timeout_err, 1);
        check("x_hold", X, m_x);
        check("y_hold", Y, m_y);
        check("btn_hold", BTN, m_btn);
        check("dir_hold", DIR, m_dir);
        m_err = 1'b1;
        // One RELEASE cycle, then a full idle period before the next request
        wait_req(n);
        check("rearm_gap", n, PollCycles + 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sndRec"}, sndRec, 0);
        check({tag, "_DIN"}, DIN, 8'h80);
        check({tag, "_X"}, X, 0);
        check({tag, "_Y"}, Y, 0);
        check({tag, "_BTN"}, BTN, 0);
        check({tag, "_DIR"}, DIR, 1);
        check({tag, "_pulses"}, {dir_valid, sample_valid}, 0);
        check({tag, "_err"}, timeout_err, 0);
    endtask

    // Monitor: every sample_valid pulse must match the oldest queued expectation
    always @(negedge CLK) begin
        if (RESET_N === 1'b1) begin
            if (sample_valid === 1'b1) begin
                check("sample_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("X", X, e.x);
                    check("Y", Y, e.y);
                    check("BTN", BTN, e.btn);
                    check("DIR", DIR, e.dir);
                    check("dir_valid", dir_valid, e.dv);
                    check("err_cleared", timeout_err, 0);
                end
            end else if (dir_valid !== 1'b0) begin
                check("dir_valid_alone", dir_valid, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, x, y, b, len;
        RESET_N = 1'b0;
        EN      = 1'b1;
        LED     = 2'b00;
        SS      = 1'b1;
        DOUT    = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1 check_reset_state("rst");
        @(negedge CLK);
        RESET_N = 1'b1;
        wait_req(n);
        check("first_req_delay", n, PollCycles);

        xfer(40'hFF_03_00_02_05, 1023, 512, 5, 1, 2, 1'b0);
        xfer(mk_dout(0, 512, 1), 0, 512, 1, 0, 1, 1'b0);
        xfer(mk_dout(512, 1023, 2), 512, 1023, 2, 2, 3, 1'b0);
        xfer(mk_dout(712, 312, 0), 712, 312, 0, 1, 1, 1'b0);
        xfer(mk_dout(713, 311, 7), 713, 311, 7, 0, 2, 1'b0);

        xfer_timeout();
        xfer(mk_dout(100, 520, 3), 100, 520, 3, 1, 2, 1'b0);

        LED = 2'b10;
        xfer(mk_dout(300, 900, 4), 300, 900, 4, 0, 3, 1'b1);
        xfer(mk_dout(900, 600, 6), 900, 600, 6, 1, 1, 1'b0);

        // Polling disabled: counter saturates, request follows one edge after re-enable
        EN = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (sndRec !== 1'b0) n++;
        end
        check("no_req_when_disabled", n, 0);
        EN = 1'b1;
        @(posedge CLK);
        #1 check("req_after_enable", sndRec, 1);
        @(negedge CLK);
        xfer(mk_dout(520, 100, 2), 520, 100, 2, 0, 2, 1'b0);

        // Asynchronous reset while in XFER
        wait_req(n);
        SS = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1 check_reset_state("midrst");
        model_reset();
        SS = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b1;
        wait_req(n);
        check("req_after_rst", n, PollCycles);
        xfer(mk_dout(1000, 30, 5), 1000, 30, 5, 1, 1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                x = $urandom_range(300, 724);
                y = $urandom_range(300, 724);
            end else begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end
            b   = $urandom_range(0, 7);
            LED = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 3);
            xfer(mk_dout(x, y, b), x, y, b, $urandom_range(0, 2), len,
                 (len >= 2) && ($urandom_range(0, 1) == 1));
        end

        repeat (4) @(negedge CLK);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
